// File: rtl/mpu_spi_byte_master.sv
// SPI mode-3 master for one 16-bit MPU9250 register transaction per start pulse.
// Frame is {rd_wr_sel, address[6:0], data[7:0]}, MSB first; read byte is returned in the low byte.
module mpu_spi_byte_master #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned SETUP_CYC = 10,
  parameter int unsigned HOLD_CYC  = 10,
  parameter int unsigned GAP_CYC   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] mpu_address,
  input  logic [7:0] mpu_wr_data,
  input  logic       mpu_rd_wr_sel,
  input  logic       start,
  output logic       busy,
  output logic [7:0] mpu_rd_data,
  output logic       SPI_SS_a,
  output logic       SPI_CK_a,
  output logic       SPI_DO_a,
  input  logic       SPI_DI_a
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

  logic [2:0]  state;
  logic [15:0] cyc;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;
  logic        rd_op;
  logic [7:0]  rd_shift;

  assign busy = start | (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cyc         <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      rd_op       <= 1'b0;
      rd_shift    <= '0;
      mpu_rd_data <= '0;
      SPI_SS_a    <= 1'b1;
      SPI_CK_a    <= 1'b1;
      SPI_DO_a    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          SPI_SS_a <= 1'b1;
          SPI_CK_a <= 1'b1;
          if (start) begin
            frame    <= {mpu_rd_wr_sel, mpu_address, mpu_rd_wr_sel ? 8'h00 : mpu_wr_data};
            rd_op    <= mpu_rd_wr_sel;
            bit_cnt  <= '0;
            cyc      <= '0;
            SPI_SS_a <= 1'b0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cyc == SETUP_LAST) begin
            cyc      <= '0;
            SPI_CK_a <= 1'b0;
            SPI_DO_a <= frame[15];
            state    <= ST_SHIFT_LO;
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        ST_SHIFT_LO: begin
          if (cyc == DIV_LAST) begin
            cyc      <= '0;
            SPI_CK_a <= 1'b1;
            // Rising SCK edge: the slave's reply occupies the second byte of the frame.
            if (bit_cnt[3]) rd_shift <= {rd_shift[6:0], SPI_DI_a};
            state    <= ST_SHIFT_HI;
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        ST_SHIFT_HI: begin
          if (cyc == DIV_LAST) begin
            cyc <= '0;
            if (bit_cnt == 4'd15) begin
              state <= ST_HOLD;
            end else begin
              // Frame is shifted so the next MOSI bit is always at the top.
              bit_cnt  <= bit_cnt + 4'd1;
              frame    <= {frame[14:0], 1'b0};
              SPI_CK_a <= 1'b0;
              SPI_DO_a <= frame[14];
              state    <= ST_SHIFT_LO;
            end
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        ST_HOLD: begin
          if (cyc == HOLD_LAST) begin
            cyc      <= '0;
            SPI_SS_a <= 1'b1;
            if (rd_op) mpu_rd_data <= rd_shift;
            state    <= ST_GAP;
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        ST_GAP: begin
          if (cyc == GAP_LAST) begin
            cyc   <= '0;
            state <= ST_IDLE;
          end else begin
            cyc <= cyc + 16'd1;
          end
        end
        default: begin
          cyc   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_spi_byte_master.sv
// Bench for mpu_spi_byte_master: SPI slave model, vector table, random frames and corner sequences.
module tb_mpu_spi_byte_master;
  localparam int unsigned DIV = 4, SU = 3, HO = 2, GP = 5;
  localparam int FRAME_CYC = 1 + SU + 32 * DIV + HO + GP;
  localparam int FAST_CYC  = 1 + 1 + 32 * 2 + 1 + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic sel = 1'b0, start = 1'b0, start2 = 1'b0;
  logic busy, busy2, ss, sck, mosi, ss2, sck2, mosi2;
  logic miso = 1'b0, miso2 = 1'b0;
  logic [7:0] rd_data, rd_data2;

  always #5 clk = ~clk;

  mpu_spi_byte_master #(.CLK_DIV(DIV), .SETUP_CYC(SU), .HOLD_CYC(HO), .GAP_CYC(GP)) dut (
    .clk(clk), .reset(reset_n), .mpu_address(addr), .mpu_wr_data(wdata),
    .mpu_rd_wr_sel(sel), .start(start), .busy(busy), .mpu_rd_data(rd_data),
    .SPI_SS_a(ss), .SPI_CK_a(sck), .SPI_DO_a(mosi), .SPI_DI_a(miso));

  mpu_spi_byte_master #(.CLK_DIV(2), .SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)) dut_fast (
    .clk(clk), .reset(reset_n), .mpu_address(addr), .mpu_wr_data(wdata),
    .mpu_rd_wr_sel(sel), .start(start2), .busy(busy2), .mpu_rd_data(rd_data2),
    .SPI_SS_a(ss2), .SPI_CK_a(sck2), .SPI_DO_a(mosi2), .SPI_DI_a(miso2));

  // Slave model: MOSI captured on SCK rise, reply byte driven on SCK fall for bits 8..15
  logic [15:0] s_word = '0;
  int s_rise = 0, s_fall = 0, ss_viol = 0;
  logic [7:0] slave_resp = '0;

  always @(negedge ss) begin s_rise = 0; s_fall = 0; s_word = '0; end
  always @(posedge sck) begin
    if (ss === 1'b0) begin s_word = {s_word[14:0], mosi}; s_rise++; end
    else if (reset_n === 1'b1) ss_viol++;
  end
  always @(negedge sck) begin
    if (ss === 1'b0) begin
      if (s_fall >= 8) miso = slave_resp[15 - s_fall];
      else miso = 1'($urandom);
      s_fall++;
    end
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one frame controller-style; optionally re-pulses start with another address mid-frame
  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                           input logic [7:0] resp, input int ignore_at, input logic [6:0] a2,
                           output int cycles);
    @(posedge clk); #1;
    sel = r; addr = a; wdata = d; slave_resp = resp; start = 1'b1;
    #1 check("busy_same_cycle", 32'(busy), 32'd1);
    cycles = 1;
    @(posedge clk); #1;
    start = 1'b0; sel = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    while (busy && cycles < 1000) begin
      if (cycles == ignore_at) begin addr = a2; start = 1'b1; end
      else start = 1'b0;
      cycles++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic rd; logic [6:0] addr; logic [7:0] wdata; logic [7:0] resp;
    logic [15:0] exp_word; logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] model_rd;
  logic [15:0] exp_word;
  int cyc, lo_run, hi_run, pulses, bad, w;
  logic r;
  logic [6:0] a;
  logic [7:0] d, resp;

  initial begin
    vecs[0] = '{1'b0, 7'h6B, 8'h00, 8'hAA, 16'h6B00, 8'h00};
    vecs[1] = '{1'b1, 7'h75, 8'h3C, 8'h71, 16'hF500, 8'h71};
    vecs[2] = '{1'b0, 7'h37, 8'h02, 8'h99, 16'h3702, 8'h71};
    vecs[3] = '{1'b1, 7'h3B, 8'hFF, 8'h5C, 16'hBB00, 8'h5C};
    vecs[4] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 16'h7FFF, 8'h5C};
    vecs[5] = '{1'b1, 7'h00, 8'h81, 8'h00, 16'h8000, 8'h00};

    #12;
    check("reset_ss", 32'(ss), 32'd1);
    check("reset_sck", 32'(sck), 32'd1);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].resp, -1, '0, cyc);
      check($sformatf("vec%0d_mosi", i), 32'(s_word), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_bits", i), 32'(s_rise), 32'd16);
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(FRAME_CYC));
    end
    model_rd = 8'h00;

    for (int i = 0; i < 10; i++) begin
      r = 1'($urandom); a = 7'($urandom); d = 8'($urandom); resp = 8'($urandom);
      exp_word = {r, a, r ? 8'h00 : d};
      if (r) model_rd = resp;
      run_frame(r, a, d, resp, -1, '0, cyc);
      check($sformatf("rand%0d_mosi", i), 32'(s_word), 32'(exp_word));
      check($sformatf("rand%0d_rd_data", i), 32'(rd_data), 32'(model_rd));
      check($sformatf("rand%0d_busy_cycles", i), 32'(cyc), 32'(FRAME_CYC));
    end

    // start pulsed 5 cycles into a frame must not queue or alter the frame
    run_frame(1'b0, 7'h12, 8'h34, 8'h00, 5, 7'h55, cyc);
    check("ignore_mosi", 32'(s_word), 32'h1234);
    check("ignore_busy_cycles", 32'(cyc), 32'(FRAME_CYC));
    @(posedge clk); #1;
    check("ignore_no_queue", 32'(busy), 32'd0);
    check("ss_low_during_sck", 32'(ss_viol), 32'd0);

    // Fast-parameter instance: exact busy length and SCK pulse shape
    @(posedge clk); #1;
    sel = 1'b0; addr = 7'h2A; wdata = 8'hC5; start2 = 1'b1;
    cyc = 1; lo_run = 0; hi_run = 0; pulses = 0; bad = 0;
    @(posedge clk); #1;
    start2 = 1'b0;
    while (busy2 && cyc < 1000) begin
      if (!sck2) begin
        if (pulses > 0 && hi_run != 0 && hi_run != 2) bad++;
        hi_run = 0; lo_run++;
      end else begin
        if (lo_run != 0) begin if (lo_run != 2) bad++; pulses++; lo_run = 0; end
        hi_run++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    check("fast_busy_cycles", 32'(cyc), 32'(FAST_CYC));
    check("fast_pulses", 32'(pulses), 32'd16);
    check("fast_pulse_shape", 32'(bad), 32'd0);
    check("fast_rd_data", 32'(rd_data2), 32'd0);

    // Mid-frame reset during a read
    run_frame(1'b1, 7'h75, 8'h00, 8'h71, -1, '0, cyc);
    check("pre_reset_rd_data", 32'(rd_data), 32'h71);
    @(posedge clk); #1;
    sel = 1'b1; addr = 7'h75; slave_resp = 8'hC3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (s_rise < 10 && w < 1000) begin @(posedge clk); #1; w++; end
    check("reach_bit9", 32'(s_rise >= 10), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_ss", 32'(ss), 32'd1);
    check("abort_sck", 32'(sck), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    run_frame(1'b0, 7'h1A, 8'h33, 8'h00, -1, '0, cyc);
    check("post_reset_mosi", 32'(s_word), 32'h1A33);
    check("post_reset_bits", 32'(s_rise), 32'd16);
    check("post_reset_busy_cycles", 32'(cyc), 32'(FRAME_CYC));
    check("post_reset_rd_data", 32'(rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
